// File: rtl/i2c_bus_arbiter_if.sv
// rtl/i2c_bus_arbiter_if.sv - write port between the bus arbiter and the I2C write engine
interface i2c_bus_arbiter_if;
    logic [15:0] write_data_o;
    logic        valid_o;
    logic        ready_i;
    logic        done_i;
    logic        error_i;

    modport master (output write_data_o, output valid_o, input ready_i, input done_i, input error_i);
    modport slave  (input write_data_o, input valid_o, output ready_i, output done_i, output error_i);
endinterface

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin arbiter sharing one I2C write engine, with done/error watchdog
// Optional burst locking is compiled in with I2C_ARB_LOCK_EN.
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [16*NUM_REQ-1:0]  req_data_i,
`ifdef I2C_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]     req_lock_i,
`endif
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     req_done_o,
    output logic [NUM_REQ-1:0]     req_error_o,
    output logic                   busy_o,
    output logic                   timeout_o,
    i2c_bus_arbiter_if.master      eng
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_ISSUE, S_WAIT, S_COMPLETE} state_t;

    state_t               state, state_nx;
    logic [IW-1:0]        ptr, ptr_nx, gnt, gnt_nx, gnt_inc;
    logic [TW-1:0]        timer, timer_nx;
    logic [15:0]          data_nx;
    logic                 valid_nx, busy_nx, timeout_nx;
    logic [NUM_REQ-1:0]   ready_nx, done_nx, error_nx;
    logic                 found;
    logic [IW-1:0]        win, cand;
`ifdef I2C_ARB_LOCK_EN
    logic [3:0]           lcnt, lcnt_nx;
    logic                 err_q, err_nx;
`endif

    assign gnt_inc = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;

    // Rotating search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = (int'(cand) == NUM_REQ - 1) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        gnt_nx     = gnt;
        timer_nx   = timer;
        data_nx    = eng.write_data_o;
        valid_nx   = 1'b0;
        timeout_nx = 1'b0;
        ready_nx   = '0;
        done_nx    = '0;
        error_nx   = '0;
`ifdef I2C_ARB_LOCK_EN
        lcnt_nx    = lcnt;
        err_nx     = err_q;
`endif
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    gnt_nx        = win;
                    data_nx       = req_data_i[16*int'(win) +: 16];
                    ready_nx[win] = 1'b1;
                    state_nx      = S_ACCEPT;
`ifdef I2C_ARB_LOCK_EN
                    if (win != ptr) lcnt_nx = '0;
`endif
                end
            end
            S_ACCEPT: begin
                state_nx = S_ISSUE;
                if (eng.ready_i) begin
                    valid_nx = 1'b1;
                    timer_nx = '0;
                end
            end
            S_ISSUE: begin
                // valid_o high here means the strobe is on the wire this cycle.
                if (eng.valid_o) begin
                    state_nx = S_WAIT;
                    timer_nx = timer + 1'b1;
                end else if (eng.ready_i) begin
                    valid_nx = 1'b1;
                    timer_nx = '0;
                end
            end
            S_WAIT: begin
                timer_nx = timer + 1'b1;
                if (eng.done_i || eng.error_i) begin
                    state_nx      = S_COMPLETE;
                    done_nx[gnt]  = 1'b1;
                    error_nx[gnt] = eng.error_i;
`ifdef I2C_ARB_LOCK_EN
                    err_nx        = eng.error_i;
`endif
                end else if (timer >= T_LAST) begin
                    state_nx      = S_COMPLETE;
                    done_nx[gnt]  = 1'b1;
                    error_nx[gnt] = 1'b1;
                    timeout_nx    = 1'b1;
`ifdef I2C_ARB_LOCK_EN
                    err_nx        = 1'b1;
`endif
                end
            end
            S_COMPLETE: begin
                state_nx = S_IDLE;
`ifdef I2C_ARB_LOCK_EN
                // lcnt counts grants already held; the 16th grant releases the lock.
                if (req_lock_i[gnt] && !err_q && lcnt != 4'd15) begin
                    lcnt_nx = lcnt + 1'b1;
                end else begin
                    ptr_nx  = gnt_inc;
                    lcnt_nx = '0;
                end
`else
                ptr_nx = gnt_inc;
`endif
            end
            default: state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state            <= S_IDLE;
            ptr              <= '0;
            gnt              <= '0;
            timer            <= '0;
            eng.write_data_o <= '0;
            eng.valid_o      <= 1'b0;
            req_ready_o      <= '0;
            req_done_o       <= '0;
            req_error_o      <= '0;
            busy_o           <= 1'b0;
            timeout_o        <= 1'b0;
`ifdef I2C_ARB_LOCK_EN
            lcnt             <= '0;
            err_q            <= 1'b0;
`endif
        end else begin
            state            <= state_nx;
            ptr              <= ptr_nx;
            gnt              <= gnt_nx;
            timer            <= timer_nx;
            eng.write_data_o <= data_nx;
            eng.valid_o      <= valid_nx;
            req_ready_o      <= ready_nx;
            req_done_o       <= done_nx;
            req_error_o      <= error_nx;
            busy_o           <= busy_nx;
            timeout_o        <= timeout_nx;
`ifdef I2C_ARB_LOCK_EN
            lcnt             <= lcnt_nx;
            err_q            <= err_nx;
`endif
        end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - self-checking bench for i2c_bus_arbiter with a transaction-level model
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;
    localparam int N  = 2;
    localparam int TO = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [16*N-1:0]  req_data = '0;
    logic [N-1:0]     req_ready, req_done, req_error;
    logic             busy, tmo;
`ifdef I2C_ARB_LOCK_EN
    logic [N-1:0]     req_lock = '0;
`endif

    i2c_bus_arbiter_if bus();

    i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
`ifdef I2C_ARB_LOCK_EN
        .req_lock_i  (req_lock),
`endif
        .req_ready_o (req_ready),
        .req_done_o  (req_done),
        .req_error_o (req_error),
        .busy_o      (busy),
        .timeout_o   (tmo),
        .eng         (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requesters, engine emulation and event monitors
    logic [15:0] wq0[$], wq1[$];
    int gnt_log[$];
    int eng_mode = 0, eng_delay = 5, eng_cnt = 0;
    int valid_cnt = 0, v_cyc = -1, first_v = -1, first_r = -1;
    int to_cyc = -1, done_cyc = -1, fall_cyc = -1, done_cnt = 0;
    logic [N-1:0] last_done = '0, last_err = '0;
    logic busy_prev = 1'b0;
    logic [15:0] w;

    always @(negedge clk) begin
        if (req_ready[0]) begin
            gnt_log.push_back(0);
            if (wq0.size() > 0) begin w = wq0.pop_front(); check("grant_word0", 32'(bus.write_data_o), 32'(w)); end
            else check("spurious_grant0", 32'(req_ready), 32'h0);
        end
        if (req_ready[1]) begin
            gnt_log.push_back(1);
            if (wq1.size() > 0) begin w = wq1.pop_front(); check("grant_word1", 32'(bus.write_data_o), 32'(w)); end
            else check("spurious_grant1", 32'(req_ready), 32'h0);
        end
        if (|req_ready && first_r < 0) first_r = cyc;
        if (tmo) to_cyc = cyc;
        if (|req_done) begin done_cnt++; last_done = req_done; last_err = req_error; done_cyc = cyc; end
        if (busy_prev && !busy) fall_cyc = cyc;
        busy_prev = busy;
        req_valid[0]     = (wq0.size() > 0);
        req_valid[1]     = (wq1.size() > 0);
        req_data[15:0]   = (wq0.size() > 0) ? wq0[0] : 16'h0;
        req_data[31:16]  = (wq1.size() > 0) ? wq1[0] : 16'h0;
    end

    // mode 0: done, 1: done+error together, 2: silent
    always @(negedge clk) begin
        bus.done_i  = 1'b0;
        bus.error_i = 1'b0;
        if (!rst_n) eng_cnt = 0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                bus.done_i  = (eng_mode == 0 || eng_mode == 1);
                bus.error_i = (eng_mode == 1);
            end
        end
        if (bus.valid_o) begin
            eng_cnt = eng_delay;
            v_cyc   = cyc;
            valid_cnt++;
            if (first_v < 0) first_v = cyc;
        end
    end

    // Model: tracks one transaction as grant / strobe age / close, and predicts next-cycle outputs.
    logic [N-1:0] e_ready = '0, e_done = '0, e_error = '0;
    logic [15:0]  e_data = '0;
    logic         e_valid = 1'b0, e_busy = 1'b0, e_to = 1'b0;
    int  m_ptr = 0, m_k = 0, m_age = -1, m_run = 0, m_idx = 0, m_win = 0;
    bit  m_active = 0, m_closing = 0, m_err = 0, m_held = 0, m_found = 0, m_hold = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_k = 0; m_age = -1; m_run = 0;
            m_active = 0; m_closing = 0; m_err = 0; m_held = 0;
            e_ready = '0; e_done = '0; e_error = '0; e_data = '0;
            e_valid = 1'b0; e_busy = 1'b0; e_to = 1'b0;
        end else begin
            e_ready = '0; e_done = '0; e_error = '0; e_valid = 1'b0; e_to = 1'b0;
            if (m_closing) begin
                m_hold = 0;
`ifdef I2C_ARB_LOCK_EN
                m_hold = req_lock[m_k] && !m_err && (m_run < 16);
`endif
                if (!m_hold) m_ptr = (m_k + 1) % N;
                m_held = m_hold;
                m_active = 0;
                m_closing = 0;
            end else if (!m_active) begin
                m_found = 0;
                for (int i = 0; i < N; i++) begin
                    m_idx = (m_ptr + i) % N;
                    if (!m_found && req_valid[m_idx]) begin m_found = 1; m_win = m_idx; end
                end
                if (m_found) begin
                    m_run = (m_held && m_win == m_k) ? m_run + 1 : 1;
                    m_k = m_win;
                    m_active = 1;
                    m_age = -1;
                    e_ready[m_k] = 1'b1;
                    e_data = req_data[16*m_k +: 16];
                end
            end else if (m_age < 0) begin
                if (bus.ready_i) begin e_valid = 1'b1; m_age = 0; end
            end else if (m_age == 0) begin
                m_age = 1;
            end else begin
                if (bus.done_i || bus.error_i) begin
                    m_err = bus.error_i;
                    e_done[m_k] = 1'b1; e_error[m_k] = m_err; m_closing = 1;
                end else if (m_age == TO - 1) begin
                    m_err = 1;
                    e_done[m_k] = 1'b1; e_error[m_k] = 1'b1; e_to = 1'b1; m_closing = 1;
                end else begin
                    m_age++;
                end
            end
            e_busy = m_active;
        end
    end

    logic [31:0] dut_vec, exp_vec;
    assign dut_vec = {7'd0, req_ready, req_done, req_error, bus.write_data_o, bus.valid_o, busy, tmo};
    assign exp_vec = {7'd0, e_ready, e_done, e_error, e_data, e_valid, e_busy, e_to};

    always @(negedge clk) check($sformatf("outputs@%0d", cyc), dut_vec, exp_vec);

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wq0.size() == 0 && wq1.size() == 0 && !busy) && n <= budget);
        check({tag, "_idle"}, 32'(n <= budget), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int rel_cyc, mark, n;
        bus.ready_i = 1'b1;
        bus.done_i  = 1'b0;
        bus.error_i = 1'b0;
        wq0.push_back(16'hA000); wq0.push_back(16'hA001);
        wq1.push_back(16'hB000); wq1.push_back(16'hB001);

        repeat (4) @(negedge clk);
        check("reset_outputs", dut_vec, 32'h0);
        check("reset_no_strobe", 32'(valid_cnt), 32'd0);
        rel_cyc = cyc;
        rst_n = 1'b1;

        wait_idle(400, "contention");
        check("cont_count", 32'(gnt_log.size()), 32'd4);
        check("cont_g0", 32'(gnt_log[0]), 32'd0);
        check("cont_g1", 32'(gnt_log[1]), 32'd1);
        check("cont_g2", 32'(gnt_log[2]), 32'd0);
        check("cont_g3", 32'(gnt_log[3]), 32'd1);
        check("ready_latency", 32'(first_r - rel_cyc), 32'd1);
        check("strobe_latency", 32'(first_v - first_r), 32'd1);
        check("done_pulses", 32'(done_cnt), 32'd4);

        gnt_log.delete();
        eng_mode = 1;
        bus.ready_i = 1'b0;
        wq1.push_back(16'h1280);
        repeat (6) @(negedge clk);
        bus.ready_i = 1'b1;
        wait_idle(200, "nack");
        check("nack_grant", 32'(gnt_log.size() == 1 && gnt_log[0] == 1), 32'd1);
        check("nack_done", 32'(last_done), 32'h2);
        check("nack_error", 32'(last_err), 32'h2);
        gnt_log.delete();
        eng_mode = 0;
        wq0.push_back(16'hC000); wq1.push_back(16'hC001);
        wait_idle(400, "nack_after");
        check("nack_after_count", 32'(gnt_log.size()), 32'd2);
        check("nack_ptr_advance", 32'(gnt_log[0]), 32'd0);

        eng_mode = 2;
        wq0.push_back(16'hD000);
        wait_idle(200, "timeout");
        check("timeout_delay", 32'(to_cyc - v_cyc), 32'd10);
        check("timeout_done_delay", 32'(done_cyc - v_cyc), 32'd10);
        check("timeout_err", 32'(last_err), 32'h1);
        check("timeout_busy_fall", 32'(fall_cyc - to_cyc), 32'd1);

        gnt_log.delete();
        mark = valid_cnt;
        wq1.push_back(16'hE001);
        n = 0;
        while (valid_cnt == mark && n < 100) begin @(negedge clk); n++; end
        check("mid_strobe_seen", 32'(valid_cnt != mark), 32'd1);
        repeat (3) @(negedge clk);
        check("mid_busy_in_wait", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("mid_reset_outputs", dut_vec, 32'h0);
        eng_mode = 0;
        wq0.push_back(16'hE100); wq1.push_back(16'hE101);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle(400, "mid_reset");
        check("mid_count", 32'(gnt_log.size()), 32'd3);
        check("mid_first_after", 32'(gnt_log[1]), 32'd0);
        check("mid_second_after", 32'(gnt_log[2]), 32'd1);

`ifdef I2C_ARB_LOCK_EN
        gnt_log.delete();
        req_lock = 2'b01;
        for (int i = 0; i < 20; i++) wq0.push_back(16'hF000 + 16'(i));
        wq1.push_back(16'hF100);
        wait_idle(2000, "lock");
        check("lock_count", 32'(gnt_log.size()), 32'd21);
        for (int i = 0; i < 16; i++) check($sformatf("lock_g%0d", i), 32'(gnt_log[i]), 32'd0);
        check("lock_release", 32'(gnt_log[16]), 32'd1);
        check("lock_resume", 32'(gnt_log[17]), 32'd0);
        req_lock = 2'b00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
